// File: rtl/universal_shift_register.sv
// WIDTH-bit universal register: load, shifts, rotates and clear on one edge, plus a
// saturating count of lossy shifts so a controller can tell when the loaded word has drained.
module universal_shift_register #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;

  assign mode_s  = mode_e'(mode);
  // Lossy shifts stop counting at WIDTH; the data keeps shifting regardless.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      unique case (mode_s)
        M_HOLD:  ;
        M_LOAD:  begin q_d = d;                           cnt_d = '0;      end
        M_SHL:   begin q_d = {q_q[WIDTH-2:0], sin_r};     cnt_d = cnt_inc; end
        M_SHR:   begin q_d = {sin_l, q_q[WIDTH-1:1]};     cnt_d = cnt_inc; end
        M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        M_ASR:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; cnt_d = cnt_inc; end
        M_CLEAR: begin q_d = '0;                          cnt_d = '0;      end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q         = q_q;
  assign sout_l    = q_q[WIDTH-1];
  assign sout_r    = q_q[0];
  assign shift_cnt = cnt_q;
  assign drained   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed vector table plus hand-written drain/restart sequence for universal_shift_register
// at WIDTH=8, RESET_VAL=8'hA5.
module tb_universal_shift_register;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] SHL   = 3'b010;
  localparam logic [2:0] SHR   = 3'b011;
  localparam logic [2:0] ROL   = 3'b100;
  localparam logic [2:0] ROR   = 3'b101;
  localparam logic [2:0] ASR   = 3'b110;
  localparam logic [2:0] CLEAR = 3'b111;

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l, sout_r, drained;
  logic [3:0] shift_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  universal_shift_register #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q        (q),
    .sout_l   (sout_l),
    .sout_r   (sout_r),
    .shift_cnt(shift_cnt),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] eq;
    logic [3:0] ec;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic e, logic [2:0] m, logic [7:0] dd,
                              logic sl, logic sr, logic [7:0] eq, logic [3:0] ec, logic ed);
    vec_t v;
    v.rst = rst; v.en = e; v.mode = m; v.d = dd; v.sl = sl; v.sr = sr;
    v.eq = eq; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic sl, input logic sr);
    @(negedge clk);
    reset = rst; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mq;
    reset = 1'b0; en = 1'b0; mode = HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;

    // reset beats en/LOAD
    vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0, 0));
    // load and SHL
    vecs.push_back(mk(0, 1, LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h02, 1, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h04, 2, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h08, 3, 0));
    // rotates and ASR
    vecs.push_back(mk(0, 1, LOAD, 8'h96, 0, 0, 8'h96, 0, 0));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h4B, 0, 0));
    vecs.push_back(mk(0, 1, ROL,  8'h00, 0, 0, 8'h96, 0, 0));
    vecs.push_back(mk(0, 1, ASR,  8'h00, 0, 0, 8'hCB, 1, 0));
    vecs.push_back(mk(0, 1, ASR,  8'h00, 0, 0, 8'hE5, 2, 0));
    // drain with sin_l=1 and saturation
    vecs.push_back(mk(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'h9E, 1, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hCF, 2, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hE7, 3, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hF3, 4, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hF9, 5, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hFC, 6, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hFE, 7, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hFF, 8, 1));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hFF, 8, 1));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hFF, 8, 1));
    // en=0 freezes everything for every mode
    for (int m = 0; m < 8; m++)
      vecs.push_back(mk(0, 0, 3'(m), 8'h12, 0, 1, 8'hFF, 8, 1));
    vecs.push_back(mk(0, 1, CLEAR, 8'h12, 0, 0, 8'h00, 0, 0));
    // reset mid-operation
    vecs.push_back(mk(0, 1, LOAD, 8'hC3, 0, 0, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h86, 1, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h0C, 2, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h18, 3, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h30, 4, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h60, 5, 0));
    vecs.push_back(mk(1, 1, SHL,  8'h00, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 1, 8'h4B, 1, 0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.en, v.mode, v.d, v.sl, v.sr);
      chk($sformatf("v%0d q", i),       32'(q),         32'(v.eq));
      chk($sformatf("v%0d cnt", i),     32'(shift_cnt), 32'(v.ec));
      chk($sformatf("v%0d drained", i), 32'(drained),   32'(v.ed));
      chk($sformatf("v%0d sout_l", i),  32'(sout_l),    32'(v.eq[7]));
      chk($sformatf("v%0d sout_r", i),  32'(sout_r),    32'(v.eq[0]));
    end

    // MSB-first drain via SHL: serial output is sampled before each shift edge
    drive(0, 1, LOAD, 8'h55, 0, 0);
    mq = 8'h55;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("seq sout_l pre%0d", k),  32'(sout_l),  32'(mq[7]));
      chk($sformatf("seq drained pre%0d", k), 32'(drained), 32'(0));
      drive(0, 1, SHL, 8'h00, 0, 1);
      mq = {mq[6:0], 1'b1};
      chk($sformatf("seq q%0d", k),   32'(q),         32'(mq));
      chk($sformatf("seq cnt%0d", k), 32'(shift_cnt), 32'(k + 1));
    end
    chk("seq drained end", 32'(drained), 32'(1));
    // LOAD straight after the drain restarts the count
    drive(0, 1, LOAD, 8'hAA, 0, 0);
    chk("restart q",       32'(q),         32'(8'hAA));
    chk("restart cnt",     32'(shift_cnt), 32'(0));
    chk("restart drained", 32'(drained),   32'(0));
    drive(0, 1, ASR, 8'h00, 0, 0);
    chk("asr q",   32'(q),         32'(8'hD5));
    chk("asr cnt", 32'(shift_cnt), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised WIDTH-bit universal register: parallel load, logical/arithmetic shifts, rotates and clear, all on one clock edge. It succeeds the fixed 8-bit parallel-load register as the general storage/serialiser element for lab datapaths. A saturating shift counter and a `drained` flag let a controller tell when every loaded bit has been shifted out.

## Interface
- `WIDTH`, 8, register width in bits; legal range is WIDTH ≥ 2.
- `RESET_VAL`, 0, value `q` takes on reset; WIDTH bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: operation enable; 0 = hold everything.
- `mode` input 3: operation select (encoding below).
- `d` input WIDTH: parallel load data.
- `sin_l` input 1: serial input entering at MSB on SHR.
- `sin_r` input 1: serial input entering at LSB on SHL.
- `q` output WIDTH: register contents; bit WIDTH-1 is MSB.
- `sout_l` output 1: combinational `q[WIDTH-1]`.
- `sout_r` output 1: combinational `q[0]`.
- `shift_cnt` output CW: count of lossy shifts since last LOAD/CLEAR/reset; CW = $clog2(WIDTH+1).
- `drained` output 1: combinational, 1 iff `shift_cnt == WIDTH`.

## Operation
- Mode encoding and next-state of `q` when `en=1`:
  - 000 HOLD: `q` unchanged.
  - 001 LOAD: `q <= d`.
  - 010 SHL: `q <= {q[W-2:0], sin_r}`.
  - 011 SHR: `q <= {sin_l, q[W-1:1]}`.
  - 100 ROL: `q <= {q[W-2:0], q[W-1]}`.
  - 101 ROR: `q <= {q[0], q[W-1:1]}`.
  - 110 ASR: `q <= {q[W-1], q[W-1:1]}`.
  - 111 CLEAR: `q <= 0`. This clears to 0, not to RESET_VAL.
- Counter update when `en=1`:
  - LOAD and CLEAR set `shift_cnt` to 0.
  - SHL, SHR and ASR increment it, saturating at WIDTH. It never wraps.
  - HOLD, ROL and ROR leave it unchanged, since rotates lose no data.
- `en=0`: `q` and `shift_cnt` hold for any `mode`.
- Priority: `reset` > `en` > `mode`.
- `sout_l` and `sout_r` reflect the current `q`, not the next value. A serial consumer samples them in the same cycle the shift is issued.
- Serialisation example, LSB first:
  - LOAD, then issue SHR WIDTH times, reading `sout_r` before each edge.
  - `drained` rises on the edge of the WIDTH-th shift.

## Timing
- Reset, on the rising edge with `reset=1`: `q=RESET_VAL`, `shift_cnt=0`, hence `drained=0`.
  - This holds regardless of `en`/`mode`, including mid-serialisation.
- Latency: one cycle for every mode. Updated `q` and `shift_cnt` are visible after the edge.
- `sout_l`, `sout_r` and `drained` are combinational from registered state. There is no additional latency and no input-to-output combinational path.
- Back-to-back modes are allowed every cycle with no bubble. LOAD immediately after a shift restarts the count from 0.
- At saturation (`shift_cnt == WIDTH`), further SHL/SHR/ASR keep the count at WIDTH and still shift data.
- Inputs `d`, `sin_l`, `sin_r`, `mode` and `en` are sampled only at the rising edge. There are no handshakes and no multi-cycle states.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'hA5.
- Reset:
  - Stimulus: assert `reset` with `en=1`, `mode=LOAD`, `d=8'hFF`.
  - Required: after the edge, `q=8'hA5`, `shift_cnt=0`, `drained=0`, `sout_l=1`, `sout_r=1`.
- Load and SHL:
  - Stimulus: LOAD 8'h81, then SHL with `sin_r=0`, three cycles.
  - Required: `q` goes 8'h02, 8'h04, 8'h08.
  - Required: `sout_l` is 1 in the cycle of the first SHL, 0 after.
  - Required: `shift_cnt` reaches 3.
- Rotate and ASR:
  - Stimulus: LOAD 8'h96, then ROR, ROL, ASR, ASR.
  - Required: `q` goes 8'h4B, 8'h96, 8'hCB, 8'hE5.
  - Required: `shift_cnt` stays 0 through the rotates and is 2 at the end.
- Drain and saturation:
  - Stimulus: LOAD 8'h3C, then 10 SHR cycles with `sin_l=1`.
  - Required: `sout_r` sequence over the first 8 shifts is 0,0,1,1,1,1,0,0.
  - Required: `drained` rises after the 8th shift; `shift_cnt` stays 8 through shifts 9–10; final `q=8'hFF`.
- Enable and CLEAR:
  - Stimulus: with `en=0`, apply every mode for one cycle each.
  - Required: `q` and `shift_cnt` are unchanged throughout.
  - Stimulus: then `en=1` with CLEAR.
  - Required: `q=8'h00` (not 8'hA5), `shift_cnt=0`.
- Reset mid-operation:
  - Stimulus: LOAD, 5 SHL, then assert `reset` concurrently with a SHL.
  - Required: `q=8'hA5`, `shift_cnt=0`.
  - Stimulus: the next SHL with `sin_r=1`.
  - Required: `q=8'h4B`, `shift_cnt=1`.
